// File: rtl/mbc3_pkg.sv
// Shared constants and types for the MBC3 cartridge controller.
package mbc3_pkg;

    localparam logic [15:0] RAMG_LO  = 16'h0000;
    localparam logic [15:0] RAMG_HI  = 16'h1FFF;
    localparam logic [15:0] ROMB_LO  = 16'h2000;
    localparam logic [15:0] ROMB_HI  = 16'h3FFF;
    localparam logic [15:0] SEL_LO   = 16'h4000;
    localparam logic [15:0] SEL_HI   = 16'h5FFF;
    localparam logic [15:0] LATCH_LO = 16'h6000;
    localparam logic [15:0] LATCH_HI = 16'h7FFF;
    localparam logic [15:0] ROM0_LO  = 16'h0000;
    localparam logic [15:0] ROMX_LO  = 16'h4000;
    localparam logic [15:0] ROMX_HI  = 16'h7FFF;
    localparam logic [15:0] XRAM_LO  = 16'hA000;
    localparam logic [15:0] XRAM_HI  = 16'hBFFF;

    localparam logic [3:0] RTC_S  = 4'h8;
    localparam logic [3:0] RTC_M  = 4'h9;
    localparam logic [3:0] RTC_H  = 4'hA;
    localparam logic [3:0] RTC_DL = 4'hB;
    localparam logic [3:0] RTC_DH = 4'hC;

    localparam logic [3:0] RAM_EN_KEY = 4'hA;

    typedef struct packed {
        logic       carry;
        logic       halt;
        logic [8:0] day;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } rtc_t;

    function automatic logic in_range(input logic [15:0] a, input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/cart_mbc3_if.sv
// CPU-facing cartridge bus: address, data both ways and the access strobes.
interface cart_mbc3_if;
    logic [15:0] a;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        rd;
    logic        wr;
    logic        cs;

    modport master (output a, din, rd, wr, cs, input dout);
    modport slave  (input a, din, rd, wr, cs, output dout);
endinterface

// File: rtl/mbc3_rtc.sv
// MBC3 real-time clock: prescaler, S/M/H/day counter chain, CPU write port
// and the latched snapshot the CPU reads.
module mbc3_rtc
    import mbc3_pkg::*;
#(
    parameter int TICK_DIV = 4194304
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sel,
    input  logic [7:0] wdata,
    input  logic       we,
    input  logic       latch,
    output rtc_t       latched
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);

    rtc_t          live, live_next;
    logic [PW-1:0] pre_cnt;
    logic          tick;

    // Prescaler is a down-counter; reaching zero is one elapsed second.
    assign tick = ~live.halt && (pre_cnt == '0);

    // Next live value: a CPU write wins over a coincident tick.
    always_comb begin
        live_next = live;
        if (we) begin
            case (sel)
                RTC_S:  live_next.s = wdata[5:0];
                RTC_M:  live_next.m = wdata[5:0];
                RTC_H:  live_next.h = wdata[4:0];
                RTC_DL: live_next.day[7:0] = wdata;
                RTC_DH: begin
                    live_next.carry  = wdata[7];
                    live_next.halt   = wdata[6];
                    live_next.day[8] = wdata[0];
                end
                default: ;
            endcase
        end else if (tick) begin
            // Out-of-range values (63, 31) wrap naturally with no carry.
            live_next.s = live.s + 6'd1;
            if (live.s == 6'd59) begin
                live_next.s = '0;
                live_next.m = live.m + 6'd1;
                if (live.m == 6'd59) begin
                    live_next.m = '0;
                    live_next.h = live.h + 5'd1;
                    if (live.h == 5'd23) begin
                        live_next.h   = '0;
                        live_next.day = live.day + 9'd1;
                        if (live.day == 9'd511) live_next.carry = 1'b1;
                    end
                end
            end
        end
    end

    // Prescaler: reloads on wrap or on a seconds write, frozen while halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= PRE_TOP;
        end else if (we && (sel == RTC_S)) begin
            pre_cnt <= PRE_TOP;
        end else if (!live.halt) begin
            pre_cnt <= (pre_cnt == '0) ? PRE_TOP : pre_cnt - 1'b1;
        end
    end

    // Live counters and the snapshot taken on the latch pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            live    <= '0;
            latched <= '0;
        end else begin
            live <= live_next;
            if (latch) latched <= live;
        end
    end

endmodule

// File: rtl/cart_mbc3.sv
// MBC3 cartridge responder: bus decode, bank registers, RAM strobe and
// read-data mux; the clock itself lives in mbc3_rtc.
module cart_mbc3
    import mbc3_pkg::*;
#(
    parameter int ROM_BANKS = 128,
    parameter int RAM_BANKS = 4,
    parameter int TICK_DIV  = 4194304
) (
    input  logic        clk,
    input  logic        rst,
    cart_mbc3_if.slave  bus,
    output logic [20:0] rom_a,
    input  logic [7:0]  rom_rdata,
    output logic [14:0] ram_a,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata
);
    localparam logic [6:0] ROM_MASK = 7'(ROM_BANKS - 1);
    localparam logic [1:0] RAM_MASK = 2'(RAM_BANKS - 1);

    logic       wr_q, wr_evt, ram_en, latch_armed, latch_pulse, rtc_we;
    logic       in_xram, in_romx, sel_ram, sel_rtc;
    logic [6:0] rom_bank;
    logic [3:0] sel;
    rtc_t       rtc_lat;
    logic       unused_rd;

    assign unused_rd   = bus.rd;
    assign wr_evt      = bus.wr & ~wr_q & bus.cs;
    assign in_xram     = in_range(bus.a, XRAM_LO, XRAM_HI);
    assign in_romx     = in_range(bus.a, ROMX_LO, ROMX_HI);
    assign sel_ram     = (sel < 4'd4);
    assign sel_rtc     = (sel >= RTC_S) && (sel <= RTC_DH);
    assign latch_pulse = wr_evt & in_range(bus.a, LATCH_LO, LATCH_HI)
                       & (bus.din == 8'h01) & latch_armed;
    assign rtc_we      = wr_evt & in_xram & ram_en & sel_rtc;

    assign rom_a     = in_romx ? {rom_bank & ROM_MASK, bus.a[13:0]} : {7'd0, bus.a[13:0]};
    assign ram_a     = {sel[1:0] & RAM_MASK, bus.a[12:0]};
    assign ram_wdata = bus.din;

    // Control registers and the RAM write strobe, all driven by the write edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q        <= 1'b0;
            ram_en      <= 1'b0;
            rom_bank    <= 7'd1;
            sel         <= 4'd0;
            latch_armed <= 1'b0;
            ram_we      <= 1'b0;
        end else begin
            wr_q   <= bus.wr;
            ram_we <= wr_evt & ram_en & sel_ram & in_xram;
            if (wr_evt) begin
                if (in_range(bus.a, RAMG_LO, RAMG_HI)) ram_en <= (bus.din[3:0] == RAM_EN_KEY);
                if (in_range(bus.a, ROMB_LO, ROMB_HI))
                    rom_bank <= (bus.din[6:0] == 7'd0) ? 7'd1 : bus.din[6:0];
                if (in_range(bus.a, SEL_LO, SEL_HI)) sel <= bus.din[3:0];
                if (in_range(bus.a, LATCH_LO, LATCH_HI)) latch_armed <= (bus.din == 8'h00);
            end
        end
    end

    // Read data: ROM below 8000, gated RAM/RTC window at A000-BFFF, else open bus.
    always_comb begin
        bus.dout = 8'hFF;
        if (in_range(bus.a, ROM0_LO, ROMX_HI)) begin
            bus.dout = rom_rdata;
        end else if (in_xram && ram_en) begin
            if (sel_ram) begin
                bus.dout = ram_rdata;
            end else begin
                case (sel)
                    RTC_S:  bus.dout = {2'b00, rtc_lat.s};
                    RTC_M:  bus.dout = {2'b00, rtc_lat.m};
                    RTC_H:  bus.dout = {3'b000, rtc_lat.h};
                    RTC_DL: bus.dout = rtc_lat.day[7:0];
                    RTC_DH: bus.dout = {rtc_lat.carry, rtc_lat.halt, 5'b00000, rtc_lat.day[8]};
                    default: ;
                endcase
            end
        end
    end

    mbc3_rtc #(.TICK_DIV(TICK_DIV)) u_rtc (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel),
        .wdata   (bus.din),
        .we      (rtc_we),
        .latch   (latch_pulse),
        .latched (rtc_lat)
    );

endmodule
